mps_op_plant_emu: RTL and testbench

- Synthesizable plant/feedback responder for the MPS on/off operation sequencers. It lets the operation FSMs and the MPS system FSM run in hardware-in-the-loop without real power stages.
- Watches the on-sequence and off-sequence state codes. After a programmable delay, it answers each "check" state by driving the external DI feedback bits and the DC-link voltage word (IEEE-754 single) that those sequencers wait on.
- Per-check fault mask suppresses individual answers so timeout/interlock paths can be exercised.

---
 rtl/mps_op_plant_emu.sv | 157 +++++++++++++++
 tb/tb_mps_op_plant_emu.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mps_op_plant_emu.sv
// Plant/feedback responder for the MPS on/off sequencers: answers check states
// with DI feedback and DC-link voltage after a programmable delay.
module mps_op_plant_emu #(
  parameter int unsigned P_RESP_DLY = 20,
  parameter logic [3:0]  P_DI_RST   = 4'b1000,
  parameter logic [31:0] P_DC_ON    = 32'h438C8000,
  parameter logic [31:0] P_DC_OFF   = 32'h41100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [3:0]  i_on_state,
  input  logic [3:0]  i_off_state,
  input  logic [6:0]  i_fault_mask,
  output logic [3:0]  o_ext_di,
  output logic [31:0] o_dc_v,
  output logic        o_busy,
  output logic        o_ack
);

  localparam int unsigned CODE_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DI_W   = 4;
  localparam int unsigned DC_W   = 32;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(P_RESP_DLY - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_APPLY = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CODE_W-1:0]  r_on;
  logic [CODE_W-1:0]  r_off;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [DI_W-1:0]    w_di_nxt;
  logic [DC_W-1:0]    w_dc_nxt;
  logic               w_ack_nxt;

  logic               w_on_new;
  logic               w_off_new;
  logic               w_evt;
  logic               w_map;
  logic               w_arm;
  logic [IDX_W-1:0]   w_idx;
  logic [7:0]         w_mask8;

  // New-code detection and response lookup; an off event shadows an on event.
  always_comb begin
    w_on_new  = (i_on_state != r_on);
    w_off_new = (i_off_state != r_off);
    w_evt     = w_on_new | w_off_new;
    w_map     = 1'b0;
    w_idx     = '0;
    w_mask8   = {1'b0, i_fault_mask};
    if (w_off_new) begin
      if (i_off_state == CODE_W'(2)) begin
        w_map = 1'b1;
        w_idx = IDX_W'(6);
      end
    end else if (w_on_new) begin
      case (i_on_state)
        CODE_W'(2):  begin w_map = 1'b1; w_idx = IDX_W'(0); end
        CODE_W'(4):  begin w_map = 1'b1; w_idx = IDX_W'(1); end
        CODE_W'(6):  begin w_map = 1'b1; w_idx = IDX_W'(2); end
        CODE_W'(8):  begin w_map = 1'b1; w_idx = IDX_W'(3); end
        CODE_W'(10): begin w_map = 1'b1; w_idx = IDX_W'(4); end
        CODE_W'(12): begin w_map = 1'b1; w_idx = IDX_W'(5); end
        default:     begin w_map = 1'b0; w_idx = '0; end
      endcase
    end
    w_arm = w_map & ~w_mask8[w_idx];
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_di_nxt    = o_ext_di;
    w_dc_nxt    = o_dc_v;
    w_ack_nxt   = 1'b0;
    if (!i_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_evt && w_arm) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_LOAD;
            w_idx_nxt   = w_idx;
          end
        end
        S_WAIT: begin
          if (w_evt) begin
            if (w_arm) begin
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = CNT_LOAD;
              w_idx_nxt   = w_idx;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else if (r_cnt == '0) begin
            w_state_nxt = S_APPLY;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        S_APPLY: begin
          w_state_nxt = S_IDLE;
          w_ack_nxt   = 1'b1;
          case (r_idx)
            IDX_W'(0), IDX_W'(1): w_di_nxt[3] = 1'b0;
            IDX_W'(2):            w_di_nxt[2] = 1'b1;
            IDX_W'(3):            w_dc_nxt    = P_DC_ON;
            IDX_W'(4):            w_di_nxt[1] = 1'b1;
            IDX_W'(5):            w_di_nxt[2] = 1'b0;
            IDX_W'(6):            w_dc_nxt    = P_DC_OFF;
            default:              w_ack_nxt   = 1'b1;
          endcase
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_on     <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      o_ext_di <= P_DI_RST;
      o_dc_v   <= '0;
      o_busy   <= 1'b0;
      o_ack    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_on     <= i_on_state;
      r_off    <= i_off_state;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      o_ext_di <= w_di_nxt;
      o_dc_v   <= w_dc_nxt;
      o_busy   <= (w_state_nxt == S_WAIT);
      o_ack    <= w_ack_nxt;
    end
  end

endmodule

// File: tb/tb_mps_op_plant_emu.sv
// Directed bench for mps_op_plant_emu with a response scoreboard keyed on o_ack.
module tb_mps_op_plant_emu;

  localparam int unsigned D      = 20;
  localparam logic [31:0] DC_ON  = 32'h438C8000;
  localparam logic [31:0] DC_OFF = 32'h41100000;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [3:0]  i_on_state;
  logic [3:0]  i_off_state;
  logic [6:0]  i_fault_mask;
  logic [3:0]  o_ext_di;
  logic [31:0] o_dc_v;
  logic        o_busy;
  logic        o_ack;

  typedef struct {
    logic [3:0]  di;
    logic [31:0] dc;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_ack = 0;
  int          a0;
  logic [3:0]  m_di;
  logic [31:0] m_dc;
  logic        busy_seen;
  int          codes[6] = '{2, 4, 6, 8, 10, 12};

  mps_op_plant_emu #(.P_RESP_DLY(D)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_on_state   (i_on_state),
    .i_off_state  (i_off_state),
    .i_fault_mask (i_fault_mask),
    .o_ext_di     (o_ext_di),
    .o_dc_v       (o_dc_v),
    .o_busy       (o_busy),
    .o_ack        (o_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model the response table and queue the expected answer and its cycle.
  task automatic push_resp(input int idx);
    case (idx)
      0, 1: m_di[3] = 1'b0;
      2:    m_di[2] = 1'b1;
      3:    m_dc    = DC_ON;
      4:    m_di[1] = 1'b1;
      5:    m_di[2] = 1'b0;
      6:    m_dc    = DC_OFF;
      default: m_dc = m_dc;
    endcase
    sb.push_back('{m_di, m_dc, cyc + D + 2});
  endtask

  always @(negedge clk) begin
    if (o_ack === 1'b1) begin
      n_ack++;
      if (sb.size() == 0) begin
        chk("ack_expected", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_di", 32'(o_ext_di), 32'(mon_e.di));
        chk("ack_dc", o_dc_v, mon_e.dc);
        chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    i_rst = 1'b1; i_en = 1'b0; i_on_state = '0; i_off_state = '0; i_fault_mask = '0;
    m_di = 4'b1000; m_dc = '0;
    tick(3);
    chk("rst_di", 32'(o_ext_di), 32'h8);
    chk("rst_dc", o_dc_v, 32'h0);
    chk("rst_busy", 32'(o_busy), 32'h0);
    chk("rst_ack", 32'(o_ack), 32'h0);
    i_rst = 1'b0; i_en = 1'b1;
    tick(2);

    // single phase-check response and exact latency
    a0 = n_ack;
    i_on_state = 4'd2; push_resp(0);
    tick(1);
    chk("t1_busy", 32'(o_busy), 32'h1);
    tick(20);
    chk("t1_di_early", 32'(o_ext_di), 32'h8);
    chk("t1_acks_early", 32'(n_ack - a0), 32'd0);
    tick(1);
    chk("t1_di", 32'(o_ext_di), 32'h0);
    chk("t1_busy_after", 32'(o_busy), 32'h0);
    tick(5);
    chk("t1_acks", 32'(n_ack - a0), 32'd1);

    // full on sequence then off DC check
    i_on_state = 4'd0;
    tick(5);
    a0 = n_ack;
    for (int i = 0; i < 6; i++) begin
      i_on_state = 4'(codes[i]); push_resp(i);
      tick(40);
    end
    chk("t2_di", 32'(o_ext_di), 32'h2);
    chk("t2_dc", o_dc_v, DC_ON);
    chk("t2_acks", 32'(n_ack - a0), 32'd6);
    i_off_state = 4'd2; push_resp(6);
    tick(40);
    chk("t2_dc_off", o_dc_v, DC_OFF);

    // masked DC link check
    i_fault_mask = 7'b0001000;
    a0 = n_ack; busy_seen = 1'b0;
    i_on_state = 4'd8;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      busy_seen = busy_seen | o_busy;
    end
    chk("t3_busy_seen", 32'(busy_seen), 32'h0);
    chk("t3_dc", o_dc_v, DC_OFF);
    chk("t3_acks", 32'(n_ack - a0), 32'd0);
    i_fault_mask = '0;

    // abort slow-on check by switching to DC link check
    a0 = n_ack;
    i_on_state = 4'd6;
    tick(10);
    i_on_state = 4'd8; push_resp(3);
    tick(40);
    chk("t4_di", 32'(o_ext_di), 32'h2);
    chk("t4_dc", o_dc_v, DC_ON);
    chk("t4_acks", 32'(n_ack - a0), 32'd1);

    // simultaneous on/off events: off wins
    i_on_state = 4'd0; i_off_state = 4'd0;
    tick(5);
    a0 = n_ack;
    i_on_state = 4'd6; i_off_state = 4'd2; push_resp(6);
    tick(40);
    chk("t5_di", 32'(o_ext_di), 32'h2);
    chk("t5_dc", o_dc_v, DC_OFF);
    chk("t5_acks", 32'(n_ack - a0), 32'd1);

    // reset during WAIT discards the pending response
    a0 = n_ack;
    i_on_state = 4'd4;
    tick(5);
    i_rst = 1'b1; i_on_state = 4'd0; i_off_state = 4'd0;
    tick(1);
    i_rst = 1'b0;
    m_di = 4'b1000; m_dc = '0;
    chk("t6_di", 32'(o_ext_di), 32'h8);
    chk("t6_dc", o_dc_v, 32'h0);
    chk("t6_busy", 32'(o_busy), 32'h0);
    tick(40);
    chk("t6_acks", 32'(n_ack - a0), 32'd0);
    chk("t6_di_hold", 32'(o_ext_di), 32'h8);

    // code already present when enable rises is not answered
    i_en = 1'b0; i_on_state = 4'd4;
    tick(3);
    i_en = 1'b1; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      busy_seen = busy_seen | o_busy;
    end
    chk("t7_busy_seen", 32'(busy_seen), 32'h0);
    chk("t7_acks", 32'(n_ack - a0), 32'd0);
    chk("t7_di", 32'(o_ext_di), 32'h8);
    i_on_state = 4'd2; push_resp(0);
    tick(40);
    chk("t7_di_resp", 32'(o_ext_di), 32'h0);
    chk("t7_acks_resp", 32'(n_ack - a0), 32'd1);

    // disabled: outputs hold, no answer
    a0 = n_ack;
    i_en = 1'b0; i_on_state = 4'd6;
    tick(40);
    chk("t8_di", 32'(o_ext_di), 32'h0);
    chk("t8_busy", 32'(o_busy), 32'h0);
    chk("t8_acks", 32'(n_ack - a0), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
